// File: rtl/decimal_tx_formatter.sv
// rtl/decimal_tx_formatter.sv - prints a binary value as ASCII decimal over a byte UART
// Optional feature: NUM_TX_SIGNED_EN (two's complement req_value with leading '-')
module decimal_tx_formatter #(
  parameter int VALUE_WIDTH = 8,
  parameter int NUM_DIGITS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [VALUE_WIDTH-1:0] req_value,
  input  logic [1:0]             req_term,
  output logic                   req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = $clog2(NUM_DIGITS + 1);
  localparam int WW = VALUE_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, CONVERT, SIGN, DIGIT, TERM1, TERM2, FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_SEND, PH_WAIT_HI, PH_WAIT_LO
  } phase_t;

  state_t        state, state_next;
  phase_t        phase;
  logic [WW-1:0] rem;
  logic [3:0]    bcd [NUM_DIGITS];
  logic [IW-1:0] pos;
  logic [IW-1:0] dig_idx;
  logic [IW-1:0] lead;
  logic          neg;
  logic [1:0]    term;
  logic [WW-1:0] pw;
  logic [WW-1:0] mag;
  logic          mag_neg;
  logic [7:0]    byte_val;
  logic          sending;
  logic          byte_done;

  function automatic logic [WW-1:0] pow10(input logic [IW-1:0] n);
    logic [WW-1:0] p;
    p = WW'(1);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) < n) p = (p << 3) + (p << 1);
    end
    return p;
  endfunction

  assign pw        = pow10(pos);
  assign byte_done = (phase == PH_WAIT_LO) && !tx_busy;

`ifdef NUM_TX_SIGNED_EN
  // Magnitude is taken one bit wider so the most-negative value fits.
  always_comb begin
    mag_neg = req_value[VALUE_WIDTH-1];
    mag     = {req_value[VALUE_WIDTH-1], req_value};
    if (mag_neg) mag = WW'(0) - mag;
  end
`else
  always_comb begin
    mag_neg = 1'b0;
    mag     = {1'b0, req_value};
  end
`endif

  // Highest nonzero position; all-zero falls back to position 0 so "0" prints.
  always_comb begin
    lead = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i] != 4'd0) lead = IW'(i);
    end
  end

  always_comb begin
    state_next = state;
    byte_val   = 8'h00;
    sending    = 1'b0;
    req_ready  = (state == IDLE);
    busy       = (state != IDLE) && (state != FINISH);
    done       = (state == FINISH);
    case (state)
      IDLE: begin
        if (req_valid) state_next = CONVERT;
      end
      CONVERT: begin
        if (rem < pw && pos == '0) state_next = neg ? SIGN : DIGIT;
      end
      SIGN: begin
        sending  = 1'b1;
        byte_val = 8'h2D;
        if (byte_done) state_next = DIGIT;
      end
      DIGIT: begin
        sending  = 1'b1;
        byte_val = {4'h3, bcd[dig_idx]};
        if (byte_done && dig_idx == '0)
          state_next = (term == 2'd1 || term == 2'd2) ? TERM1 : FINISH;
      end
      TERM1: begin
        sending  = 1'b1;
        byte_val = (term == 2'd1) ? 8'h20 : 8'h0D;
        if (byte_done) state_next = (term == 2'd2) ? TERM2 : FINISH;
      end
      TERM2: begin
        sending  = 1'b1;
        byte_val = 8'h0A;
        if (byte_done) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= PH_SEND;
      rem      <= '0;
      pos      <= '0;
      dig_idx  <= '0;
      neg      <= 1'b0;
      term     <= 2'd0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) bcd[i] <= 4'd0;
    end else begin
      state    <= state_next;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            rem  <= mag;
            neg  <= mag_neg;
            term <= req_term;
            pos  <= IW'(NUM_DIGITS - 1);
            for (int i = 0; i < NUM_DIGITS; i++) bcd[i] <= 4'd0;
          end
        end
        CONVERT: begin
          if (rem >= pw) begin
            rem      <= rem - pw;
            bcd[pos] <= bcd[pos] + 4'd1;
          end else if (pos != '0) begin
            pos <= pos - IW'(1);
          end else begin
            dig_idx <= lead;
          end
        end
        default: ;
      endcase
      if (sending) begin
        case (phase)
          PH_SEND: begin
            if (!tx_busy && !tx_start) begin
              tx_start <= 1'b1;
              tx_data  <= byte_val;
              phase    <= PH_WAIT_HI;
            end
          end
          PH_WAIT_HI: begin
            if (tx_busy) phase <= PH_WAIT_LO;
          end
          PH_WAIT_LO: begin
            if (!tx_busy) begin
              phase <= PH_SEND;
              if (state == DIGIT && dig_idx != '0) dig_idx <= dig_idx - IW'(1);
            end
          end
          default: phase <= PH_SEND;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decimal_tx_formatter.sv
// tb/tb_decimal_tx_formatter.sv - directed bench for decimal_tx_formatter with a UART busy model
module tb_decimal_tx_formatter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_value = 8'h00;
  logic [1:0] req_term = 2'd0;
  logic       req_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  logic [7:0] sent_q [$];
  logic [7:0] exp_q [$];
  int         busy_cnt = 0;
  logic       hold = 1'b0;

  decimal_tx_formatter #(.VALUE_WIDTH(8), .NUM_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value),
    .req_term(req_term), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // UART model: each strobe captures the byte and keeps tx_busy high for 10 cycles.
  assign tx_busy = (busy_cnt != 0) || hold;
  always @(posedge clk) begin
    if (tx_start) begin
      sent_q.push_back(tx_data);
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [7:0] v, input logic [1:0] t);
    @(negedge clk);
    req_value = v;
    req_term  = t;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int cnt);
    int n;
    n = 0;
    while (sent_q.size() < cnt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach"}, sent_q.size(), cnt);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_count"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < sent_q.size()) chk($sformatf("%s_byte%0d", tag, i), {24'd0, sent_q[i]}, {24'd0, exp_q[i]});
    end
    sent_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'd0, 2'd0);
    chk("zero_busy", {31'd0, busy}, 32'd1);
    wait_done("zero");
    exp_q = '{8'h30};
    check_bytes("zero");

    issue(8'd255, 2'd2);
    wait_done("v255");
`ifdef NUM_TX_SIGNED_EN
    exp_q = '{8'h2D, 8'h31, 8'h0D, 8'h0A};
`else
    exp_q = '{8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A};
`endif
    check_bytes("v255");

    issue(8'd7, 2'd1);
    repeat (5) @(negedge clk);
    chk("ign_ready", {31'd0, req_ready}, 32'd0);
    req_value = 8'd9;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_done("v7");
    exp_q = '{8'h37, 8'h20};
    check_bytes("v7");
    repeat (30) @(negedge clk);
    chk("ign_nobytes", sent_q.size(), 0);
    issue(8'd9, 2'd1);
    wait_done("v9");
    exp_q = '{8'h39, 8'h20};
    check_bytes("v9");

    issue(8'hF6, 2'd0);
    wait_done("vf6");
`ifdef NUM_TX_SIGNED_EN
    exp_q = '{8'h2D, 8'h31, 8'h30};
`else
    exp_q = '{8'h32, 8'h34, 8'h36};
`endif
    check_bytes("vf6");

`ifdef NUM_TX_SIGNED_EN
    issue(8'h80, 2'd0);
    wait_done("v80");
    exp_q = '{8'h2D, 8'h31, 8'h32, 8'h38};
    check_bytes("v80");
`endif

    issue(8'd123, 2'd0);
    wait_bytes("stall", 1);
    hold = 1'b1;
    repeat (50) @(negedge clk);
    chk("stall_nostart", sent_q.size(), 1);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    hold = 1'b0;
    wait_done("stall");
    exp_q = '{8'h31, 8'h32, 8'h33};
    check_bytes("stall");

    issue(8'd255, 2'd0);
    wait_bytes("rstmid", 2);
    rst = 1'b1;
    #1;
    chk("rstmid_start", {31'd0, tx_start}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rstmid_nostray", sent_q.size(), 2);
    sent_q.delete();
    issue(8'd42, 2'd0);
    wait_done("v42");
    exp_q = '{8'h34, 8'h32};
    check_bytes("v42");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
